pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 48 ++++
 rtl/pipe_decode.sv | 60 ++++++
 rtl/pipe_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline control slice.
// Holds the RV32I base opcode constants, the decoded opcode class, the ALU
// select codes, the flush FSM state encoding and the MEM/WB stage record.
package pipe_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_OP,
        CLS_OP_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH
    } op_class_e;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_e;

    // One slot of the MEM or WB stage register.
    typedef struct packed {
        logic       load_inst;
        logic       reg_dest;
        logic       we;
        logic [4:0] rd;
    } stage_t;

    function automatic op_class_e classify(input logic [6:0] opc);
        case (opc)
            OPC_OP:     return CLS_OP;
            OPC_OP_IMM: return CLS_OP_IMM;
            OPC_LOAD:   return CLS_LOAD;
            OPC_STORE:  return CLS_STORE;
            OPC_BRANCH: return CLS_BRANCH;
            default:    return CLS_NOP;
        endcase
    endfunction

endpackage

// File: rtl/pipe_decode.sv
// pipe_decode: purely combinational decode of the ID/EX instruction.
// Ports:
//   opcode    in  7  instruction bits [6:0]
//   func      in  4  {bit30, bits14:12}
//   ex_rd     in  5  destination register
//   op_class  out    decoded opcode class
//   branch_inst, reg_reg_inst, ex_load_inst, ex_reg_dest  out 1 each
//   alu_op    out 4  ALU select
//   write_en  out 1  instruction writes a non-zero destination register
module pipe_decode
    import pipe_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [3:0] func,
    input  logic [4:0] ex_rd,
    output op_class_e  op_class,
    output logic       branch_inst,
    output logic       reg_reg_inst,
    output logic       ex_load_inst,
    output logic       ex_reg_dest,
    output logic [3:0] alu_op,
    output logic       write_en
);

    always_comb begin
        op_class     = classify(opcode);
        branch_inst  = 1'b0;
        reg_reg_inst = 1'b0;
        ex_load_inst = 1'b0;
        ex_reg_dest  = 1'b0;
        alu_op       = ALU_ADD;
        write_en     = 1'b0;
        case (op_class)
            CLS_OP: begin
                reg_reg_inst = 1'b1;
                alu_op       = func;
                write_en     = (ex_rd != 5'd0);
            end
            CLS_OP_IMM: begin
                // Immediate forms have no SUB; bit30 only selects SRA vs SRL.
                alu_op   = (func[2:0] == 3'b101) ? func : {1'b0, func[2:0]};
                write_en = (ex_rd != 5'd0);
            end
            CLS_LOAD: begin
                ex_load_inst = 1'b1;
                write_en     = (ex_rd != 5'd0);
            end
            CLS_STORE: begin
                ex_load_inst = 1'b1;
                ex_reg_dest  = 1'b1;
            end
            CLS_BRANCH: begin
                branch_inst = 1'b1;
                alu_op      = ALU_SUB;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control for a 5-stage in-order core.
// Detects load-use hazards (stall), kills the wrong path after a taken
// branch (flush, two cycles via a RUN/FLUSH FSM), carries control through
// the MEM and WB stage registers and keeps saturating event counters.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   current_opcode, current_func     ID/EX instruction fields
//   ex_rd, if_rs1, if_rs2, if_uses_rs2   register numbers for hazard check
//   branch_taken                     EX/MEM branch resolved taken
//   branch_inst, reg_reg_inst, ex_load_inst, ex_reg_dest, alu_op   EX control
//   load_inst, reg_dest              MEM control (registered)
//   stall, flush                     pipeline hold / kill
//   reg_we, wb_rd                    WB register-file write
//   stall_count, flush_count         saturating event counters
module pipe_ctrl
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  current_opcode,
    input  logic [3:0]  current_func,
    input  logic [4:0]  ex_rd,
    input  logic [4:0]  if_rs1,
    input  logic [4:0]  if_rs2,
    input  logic        if_uses_rs2,
    input  logic        branch_taken,
    output logic        branch_inst,
    output logic        reg_reg_inst,
    output logic        ex_load_inst,
    output logic        ex_reg_dest,
    output logic        load_inst,
    output logic        reg_dest,
    output logic [3:0]  alu_op,
    output logic        stall,
    output logic        flush,
    output logic        reg_we,
    output logic [4:0]  wb_rd,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    op_class_e  dec_class;
    logic       dec_branch, dec_rr, dec_load, dec_rdst, dec_we;
    logic [3:0] dec_alu;

    pipe_decode u_decode (
        .opcode       (current_opcode),
        .func         (current_func),
        .ex_rd        (ex_rd),
        .op_class     (dec_class),
        .branch_inst  (dec_branch),
        .reg_reg_inst (dec_rr),
        .ex_load_inst (dec_load),
        .ex_reg_dest  (dec_rdst),
        .alu_op       (dec_alu),
        .write_en     (dec_we)
    );

    state_e state, state_nxt;
    logic   cnt, cnt_nxt;
    logic   load_use, flush_start;
    stage_t mem_p1, wb_p2, mem_nxt;

    assign load_use = (dec_class == CLS_LOAD) && (ex_rd != 5'd0) &&
                      ((if_rs1 == ex_rd) || (if_uses_rs2 && (if_rs2 == ex_rd)));

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        flush       = 1'b0;
        flush_start = 1'b0;
        case (state)
            ST_RUN: begin
                if (branch_taken) begin
                    flush       = 1'b1;
                    flush_start = 1'b1;
                    state_nxt   = ST_FLUSH;
                    cnt_nxt     = 1'b1;
                end
            end
            ST_FLUSH: begin
                // A branch_taken seen here belongs to the path already being killed.
                flush   = 1'b1;
                cnt_nxt = cnt - 1'b1;
                if (cnt_nxt == 1'b0) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = 1'b0;
            end
        endcase
    end

    // Flush wins over a simultaneous load-use hazard.
    assign stall = (state == ST_RUN) && load_use && !flush;

    // Killed ID/EX instructions present no EX-stage control.
    assign branch_inst  = dec_branch & ~flush;
    assign reg_reg_inst = dec_rr     & ~flush;
    assign ex_load_inst = dec_load   & ~flush;
    assign ex_reg_dest  = dec_rdst   & ~flush;
    assign alu_op       = dec_alu;

    always_comb begin
        mem_nxt = '0;
        if (!stall && !flush) begin
            mem_nxt.load_inst = dec_load;
            mem_nxt.reg_dest  = dec_rdst;
            mem_nxt.we        = dec_we;
            mem_nxt.rd        = ex_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            cnt         <= 1'b0;
            mem_p1      <= '0;
            wb_p2       <= '0;
            stall_count <= 16'd0;
            flush_count <= 16'd0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            // EX -> MEM
            mem_p1 <= mem_nxt;
            // MEM -> WB
            wb_p2  <= mem_p1;
            if (stall) begin
                stall_count <= sat_inc(stall_count);
            end
            if (flush_start) begin
                flush_count <= sat_inc(flush_count);
            end
        end
    end

    assign load_inst = mem_p1.load_inst;
    assign reg_dest  = mem_p1.reg_dest;
    assign reg_we    = wb_p2.we;
    assign wb_rd     = wb_p2.rd;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed-vector bench with a scoreboard queue.
// The driver applies one vector per cycle and pushes the hand-computed
// outputs expected in that cycle; the monitor pops and compares on the
// falling edge whenever an expectation is pending.
module tb_pipe_ctrl;

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] IMM = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] NOP = 7'b0000000;

    logic        clk;
    logic        reset;
    logic [6:0]  current_opcode;
    logic [3:0]  current_func;
    logic [4:0]  ex_rd, if_rs1, if_rs2;
    logic        if_uses_rs2, branch_taken;
    logic        branch_inst, reg_reg_inst, ex_load_inst, ex_reg_dest;
    logic        load_inst, reg_dest, stall, flush, reg_we;
    logic [3:0]  alu_op;
    logic [4:0]  wb_rd;
    logic [15:0] stall_count, flush_count;

    pipe_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .current_opcode (current_opcode),
        .current_func   (current_func),
        .ex_rd          (ex_rd),
        .if_rs1         (if_rs1),
        .if_rs2         (if_rs2),
        .if_uses_rs2    (if_uses_rs2),
        .branch_taken   (branch_taken),
        .branch_inst    (branch_inst),
        .reg_reg_inst   (reg_reg_inst),
        .ex_load_inst   (ex_load_inst),
        .ex_reg_dest    (ex_reg_dest),
        .load_inst      (load_inst),
        .reg_dest       (reg_dest),
        .alu_op         (alu_op),
        .stall          (stall),
        .flush          (flush),
        .reg_we         (reg_we),
        .wb_rd          (wb_rd),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall, flush, br, rr, exld, exrd;
        logic [3:0]  alu;
        logic        ld, rdst, we;
        logic [4:0]  wbrd;
        logic [15:0] sc, fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   row_no  = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h, expected %h", nm, row_no, act, req);
        end
    endtask

    // Monitor: compare whatever the driver expected for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                row_no++;
                chk("stall",        {15'd0, stall},        {15'd0, e.stall});
                chk("flush",        {15'd0, flush},        {15'd0, e.flush});
                chk("branch_inst",  {15'd0, branch_inst},  {15'd0, e.br});
                chk("reg_reg_inst", {15'd0, reg_reg_inst}, {15'd0, e.rr});
                chk("ex_load_inst", {15'd0, ex_load_inst}, {15'd0, e.exld});
                chk("ex_reg_dest",  {15'd0, ex_reg_dest},  {15'd0, e.exrd});
                chk("alu_op",       {12'd0, alu_op},       {12'd0, e.alu});
                chk("load_inst",    {15'd0, load_inst},    {15'd0, e.ld});
                chk("reg_dest",     {15'd0, reg_dest},     {15'd0, e.rdst});
                chk("reg_we",       {15'd0, reg_we},       {15'd0, e.we});
                chk("wb_rd",        {11'd0, wb_rd},        {11'd0, e.wbrd});
                chk("stall_count",  stall_count,           e.sc);
                chk("flush_count",  flush_count,           e.fc);
            end
        end
    end

    task automatic drive(input logic [6:0] op, input logic [3:0] fn, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                         input logic bt, input logic rst);
        @(posedge clk);
        #1;
        current_opcode = op;
        current_func   = fn;
        ex_rd          = rd;
        if_rs1         = rs1;
        if_rs2         = rs2;
        if_uses_rs2    = u2;
        branch_taken   = bt;
        reset          = rst;
    endtask

    // Drive one vector and record the outputs expected during that cycle.
    task automatic row(input logic [6:0] op, input logic [3:0] fn, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                       input logic bt, input logic rst,
                       input logic e_stall, input logic e_flush, input logic e_br,
                       input logic e_rr, input logic e_exld, input logic e_exrd,
                       input logic [3:0] e_alu, input logic e_ld, input logic e_rdst,
                       input logic e_we, input logic [4:0] e_wbrd,
                       input logic [15:0] e_sc, input logic [15:0] e_fc);
        exp_t e;
        drive(op, fn, rd, rs1, rs2, u2, bt, rst);
        e.stall = e_stall; e.flush = e_flush; e.br = e_br; e.rr = e_rr;
        e.exld = e_exld; e.exrd = e_exrd; e.alu = e_alu; e.ld = e_ld;
        e.rdst = e_rdst; e.we = e_we; e.wbrd = e_wbrd; e.sc = e_sc; e.fc = e_fc;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; current_opcode = NOP; current_func = 4'd0; ex_rd = 5'd0;
        if_rs1 = 5'd0; if_rs2 = 5'd0; if_uses_rs2 = 1'b0; branch_taken = 1'b0;

        drive(NOP, 4'h0, 0, 0, 0, 0, 0, 1);
        drive(NOP, 4'h0, 0, 0, 0, 0, 0, 1);

        //  op   fn    rd rs1 rs2 u2 bt rst | stl fl br rr xl xd alu  ld rd we wbrd  sc        fc
        row(OP,  4'h8, 5, 1, 2, 1, 0, 0,     0, 0, 0, 1, 0, 0, 4'h8, 0, 0, 0, 0,  16'd0,    16'd0);
        row(IMM, 4'hD, 7, 1, 2, 0, 0, 0,     0, 0, 0, 0, 0, 0, 4'hD, 0, 0, 0, 0,  16'd0,    16'd0);
        row(IMM, 4'h8, 9, 1, 2, 0, 0, 0,     0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 5,  16'd0,    16'd0);
        row(ST,  4'h2, 4, 4, 0, 1, 0, 0,     0, 0, 0, 0, 1, 1, 4'h0, 0, 0, 1, 7,  16'd0,    16'd0);
        row(LD,  4'h2, 3, 3, 0, 0, 0, 0,     1, 0, 0, 0, 1, 0, 4'h0, 1, 1, 1, 9,  16'd0,    16'd0);
        row(NOP, 4'h0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 4,  16'd1,    16'd0);
        row(LD,  4'h2, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0, 0,  16'd1,    16'd0);
        row(LD,  4'h2, 6, 1, 6, 1, 0, 0,     1, 0, 0, 0, 1, 0, 4'h0, 1, 0, 0, 0,  16'd1,    16'd0);
        row(LD,  4'h2, 6, 1, 6, 0, 0, 0,     0, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0, 0,  16'd2,    16'd0);
        row(LD,  4'h2, 2, 2, 0, 0, 1, 0,     0, 1, 0, 0, 0, 0, 4'h0, 1, 0, 0, 0,  16'd2,    16'd0);
        row(BR,  4'h0, 0, 0, 0, 0, 1, 0,     0, 1, 0, 0, 0, 0, 4'h8, 0, 0, 1, 6,  16'd2,    16'd1);
        row(BR,  4'h0, 0, 0, 0, 0, 0, 0,     0, 0, 1, 0, 0, 0, 4'h8, 0, 0, 0, 0,  16'd2,    16'd1);
        row(OP,  4'h0, 8, 0, 0, 0, 1, 0,     0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0,  16'd2,    16'd1);
        row(OP,  4'h7, 10, 0, 0, 0, 0, 1,    0, 1, 0, 0, 0, 0, 4'h7, 0, 0, 0, 0,  16'd2,    16'd2);
        row(OP,  4'h7, 10, 0, 0, 0, 0, 0,    0, 0, 0, 1, 0, 0, 4'h7, 0, 0, 0, 0,  16'd0,    16'd0);
        row(LD,  4'h0, 3, 3, 0, 0, 0, 0,     1, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0, 0,  16'd0,    16'd0);

        for (int i = 0; i < 65540; i++) begin
            drive(LD, 4'h0, 3, 3, 0, 0, 0, 0);
        end
        row(LD,  4'h0, 3, 3, 0, 0, 0, 0,     1, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0, 0,  16'hFFFF, 16'd0);
        row(NOP, 4'h0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0,  16'hFFFF, 16'd0);

        @(posedge clk);
        @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
